// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, queue depth, PC step.
// Optional feature macro: IF_DELAY_SLOT_EN (delay-slot preserving redirects).
package if_fetch_pkg;

    localparam int          INST_BUS      = 32;
    localparam int          INST_ADDR_BUS = 32;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic [1:0]  Q_DEPTH       = 2'd2;
    localparam logic [31:0] PC_INC        = 32'd4;

    typedef struct packed {
        logic [INST_ADDR_BUS-1:0] pc;
        logic [INST_BUS-1:0]      inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus: ROM port, pipeline control and decode handshake.
// master = fetch stage, slave = ROM/decode side.
interface if_fetch_if;

    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_ready_i;
    logic        id_valid_o;
    logic [31:0] id_inst_o;
    logic [31:0] id_pc_o;

    modport master (
        output rom_ce_o, rom_addr_o,
        output id_valid_o, id_inst_o, id_pc_o,
        input  rom_data_i, stall_i, redirect_i,
        input  redirect_pc_i, id_ready_i
    );

    modport slave (
        input  rom_ce_o, rom_addr_o,
        input  id_valid_o, id_inst_o, id_pc_o,
        output rom_data_i, stall_i, redirect_i,
        output redirect_pc_i, id_ready_i
    );

endinterface

// File: rtl/if_queue.sv
// Two-entry {pc, inst} FIFO between ROM capture and decode.
// Flush empties it; keep-head drops everything but the oldest entry.
module if_queue
    import if_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  fetch_entry_t i_entry,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic         i_keep_head,
    output logic [1:0]   o_count,
    output logic         o_valid,
    output fetch_entry_t o_head
);

    logic [1:0]   r_count;
    fetch_entry_t r_e0;
    fetch_entry_t r_e1;

    // Entry shift/fill; flush and keep-head override push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 2'd0;
            r_e0    <= '0;
            r_e1    <= '0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else if (i_keep_head) begin
            r_count <= 2'd1;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0)
                        r_e0 <= i_entry;
                    else
                        r_e1 <= i_entry;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_e0    <= r_e1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == Q_DEPTH) begin
                        r_e0 <= r_e1;
                        r_e1 <= i_entry;
                    end else begin
                        r_e0 <= i_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_valid = (r_count != 2'd0);
    assign o_head  = r_e0;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, drives the ROM, queues words for decode.
// Define IF_DELAY_SLOT_EN to keep the branch delay slot across redirects.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    if_fetch_if.master  bus
);

    logic         r_ce;
    logic [31:0]  r_pc;
    logic [1:0]   w_q_count;
    logic         w_q_valid;
    fetch_entry_t w_q_head;
    fetch_entry_t w_entry;
    logic         w_pop;
    logic         w_space;
    logic         w_accept;
    logic         w_flush;
    logic         w_keep;
`ifdef IF_DELAY_SLOT_EN
    logic         r_pend;
    logic [31:0]  r_pend_pc;
    logic         w_pend_set;
`endif

    assign w_pop    = w_q_valid & bus.id_ready_i;
    assign w_space  = (w_q_count < Q_DEPTH) | w_pop;
    assign w_accept = r_ce & ~bus.stall_i & w_space & ~bus.redirect_i;
    assign w_entry  = '{pc: r_pc, inst: bus.rom_data_i};

    // Decide how a redirect treats the queued entries
    always_comb begin
        w_flush = 1'b0;
        w_keep  = 1'b0;
`ifdef IF_DELAY_SLOT_EN
        w_pend_set = 1'b0;
        if (bus.redirect_i) begin
            if (w_q_count == 2'd0 || (w_q_count == 2'd1 && w_pop)) begin
                w_flush    = 1'b1;
                w_pend_set = 1'b1;
            end else if (w_pop) begin
                w_flush = 1'b1;
            end else begin
                w_keep = 1'b1;
            end
        end
`else
        w_flush = bus.redirect_i;
`endif
    end

    // ROM enable and PC sequencing: redirect beats accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ce <= 1'b0;
            r_pc <= RESET_PC;
`ifdef IF_DELAY_SLOT_EN
            r_pend    <= 1'b0;
            r_pend_pc <= ZERO_WORD;
`endif
        end else begin
            r_ce <= 1'b1;
`ifdef IF_DELAY_SLOT_EN
            if (w_pend_set) begin
                r_pend    <= 1'b1;
                r_pend_pc <= bus.redirect_pc_i;
            end else if (bus.redirect_i) begin
                r_pc <= bus.redirect_pc_i;
            end else if (w_accept) begin
                if (r_pend) begin
                    r_pc   <= r_pend_pc;
                    r_pend <= 1'b0;
                end else begin
                    r_pc <= r_pc + PC_INC;
                end
            end
`else
            if (bus.redirect_i)
                r_pc <= bus.redirect_pc_i;
            else if (w_accept)
                r_pc <= r_pc + PC_INC;
`endif
        end
    end

    if_queue u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_accept),
        .i_entry     (w_entry),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .i_keep_head (w_keep),
        .o_count     (w_q_count),
        .o_valid     (w_q_valid),
        .o_head      (w_q_head)
    );

    assign bus.rom_ce_o   = r_ce;
    assign bus.rom_addr_o = r_pc;
    assign bus.id_valid_o = w_q_valid;
    assign bus.id_inst_o  = w_q_valid ? w_q_head.inst : ZERO_WORD;
    assign bus.id_pc_o    = w_q_valid ? w_q_head.pc : ZERO_WORD;

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage between the on-chip instruction ROM and the decode stage inside `cpu`. It owns the PC, drives the ROM chip-enable and address, and captures each returned word with its PC into a 2-entry queue. It presents queue entries to decode through a valid/ready handshake. It also handles control-flow redirects from decode, and optionally honours the MIPS branch delay slot.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rom_ce_o`  out  1  ROM chip enable.
- `rom_addr_o`  out  32  ROM byte address (the current PC).
- `rom_data_i`  in  32  ROM instruction word. Combinational: valid in the same cycle as `rom_addr_o` while `rom_ce_o`=1.
- `stall_i`  in  1  pipeline control request to freeze fetch.
- `redirect_i`  in  1  decode requests a control-flow change.
- `redirect_pc_i`  in  32  redirect target; sampled only when `redirect_i`=1.
- `id_ready_i`  in  1  decode can accept an entry this cycle.
- `id_valid_o`  out  1  queue head is valid.
- `id_inst_o`  out  32  head instruction; 32'h0 when `id_valid_o`=0.
- `id_pc_o`  out  32  head PC; 32'h0 when `id_valid_o`=0.

## Operation
- State:
  - `ce_q`
  - `pc_q`
  - queue (`count` 0..2, two entries of {pc, inst})
  - delay-slot pending flag and target (macro build only)
- Reset values:
  - `ce_q`=0, `pc_q`=`RESET_PC`, `count`=0, pending=0.
  - `rom_ce_o`=0, `rom_addr_o`=`RESET_PC`, `id_valid_o`=0, `id_inst_o`=0, `id_pc_o`=0.
- `ce_q` goes to 1 on the first edge with `rst`=0. `rom_ce_o`=`ce_q`. `rom_addr_o`=`pc_q`.
- pop = `id_valid_o` & `id_ready_i`. The head is removed and the next entry advances.
- space = (`count`<2) | pop. A push and a pop together at `count`=2 is legal and keeps `count`=2.
- accept = `ce_q` & !`stall_i` & space & !`redirect_i`.
  - On accept: push {`pc_q`, `rom_data_i`}, then `pc_q` <= `pc_q`+4, 32-bit with wrap-around (32'hFFFF_FFFC -> 0).
- `stall_i` blocks push and PC update only; pops continue.
- A redirect without the macro:
  - Clears the whole queue, including any entry popped that same cycle; decode treats that handshake as consumed.
  - No push that cycle.
  - `pc_q` <= `redirect_pc_i`.
- Redirect has priority over stall and accept. Reset has priority over everything.
- `rom_data_i` is ignored whenever accept=0.

## Timing
- Fetch-to-decode latency is 1 cycle: a word accepted in cycle N is at the queue head in cycle N+1 if the queue was empty.
- First instruction: `rst` falls before edge E0.
  - Cycle after E0: `rom_ce_o`=1, address `RESET_PC`.
  - Next cycle: `id_valid_o`=1 with PC `RESET_PC`.
- Redirect in cycle N:
  - Cycle N+1: `rom_addr_o`=target, `id_valid_o`=0.
  - Cycle N+2: target instruction at the head (no stall).
- Sustained throughput is 1 instruction per cycle while `id_ready_i`=1 and `stall_i`=0.

## Configuration
- `IF_DELAY_SLOT_EN` defined: a redirect preserves the delay slot, i.e. the oldest instruction not yet delivered.
  - `count`>=1 and the head is not popped that cycle: keep the head, drop the other entry, `pc_q` <= target.
  - Head is popped that cycle (delay slot already delivered): flush as without the macro.
  - `count`=0, or only the popped entry remains: set pending and latch the target. `pc_q` is unchanged. The next accept pushes the delay slot normally and loads `pc_q` <= pending target instead of +4, then clears pending.
  - A redirect while pending is set overwrites the pending target.
- `IF_DELAY_SLOT_EN` undefined: the full-flush behaviour in Operation applies; no pending state exists.

## Structure
- Shared definitions header, alongside the existing bus macros:
  - `InstBus` and `InstAddrBus` widths
  - `ZeroWord`
  - queue depth constant (2)
  - PC increment constant (4)
- One sub-module, `if_queue`: a 2-entry {pc, inst} FIFO with push, pop, flush and keep-head-only flush inputs, plus count/valid outputs. PC, ROM-side and redirect logic stay in `if_fetch`.

## Test plan
- Reset released, ROM holds 0x1000_0000+addr, `id_ready_i`=1:
  - `rom_ce_o` rises 1 cycle after `rst` falls.
  - Decode sees PCs 0, 4, 8… back-to-back, with `id_inst_o` = 0x1000_0000, 0x1000_0004, …
- `id_ready_i`=0 for 5 cycles:
  - `count` saturates at 2 and `rom_addr_o` holds at 8.
  - On release, entries drain in order with no loss or duplication.
- `stall_i`=1 for 3 cycles with the queue non-empty:
  - The queue drains.
  - `rom_addr_o` is constant and no push occurs.
- Without the macro, `redirect_i` with target 0x40 while `count`=2 and pop=1:
  - Next cycle: `id_valid_o`=0, `rom_addr_o`=0x40.
  - The following cycle: `id_pc_o`=0x40.
- With `IF_DELAY_SLOT_EN`:
  - Redirect to 0x80 with head PC 0x0C, not popped: the next delivered PCs are 0x0C then 0x80.
  - Redirect with the queue empty and `pc_q`=0x10: fetches 0x10 and then 0x80.
- `RESET_PC`=32'hFFFF_FFF8: delivered PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000. Asserting `rst` mid-stream clears `id_valid_o` and reloads `RESET_PC` on that edge.
